// File: rtl/led_pwm_fader_pkg.sv
// Shared definitions for the LED PWM fader: derived timing constants,
// default-configuration value/duty types and the fade direction enum.
package led_pwm_fader_pkg;

  typedef enum logic [1:0] {
    FADE_HOLD,
    FADE_UP,
    FADE_DOWN
  } t_fade_dir;

  // PWM period in clocks
  function automatic int calc_period(input int fclk, input int period_ms);
    return (fclk / 1000) * period_ms;
  endfunction

  // On-clocks per period at full-scale value
  function automatic int calc_duty_max(input int period, input int max_pct);
    return (period / 100) * max_pct;
  endfunction

  // On-clocks contributed by one brightness LSB
  function automatic int calc_step(input int duty_max, input int value_width);
    return duty_max / ((1 << value_width) - 1);
  endfunction

  // Bits needed to hold 0..n-1 (never less than one)
  function automatic int calc_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Types for the default build (W = 8, 40 MHz, 10 ms, 80 %)
  localparam int DEF_VALUE_WIDTH = 8;
  localparam int DEF_DUTY_WIDTH  =
    calc_width(calc_duty_max(calc_period(40_000_000, 10), 80) + 1);

  typedef logic [DEF_VALUE_WIDTH-1:0] t_level;
  typedef logic [DEF_DUTY_WIDTH-1:0]  t_duty;

endpackage

// File: rtl/led_pwm_fader_channel.sv
// One PWM channel: target capture, level/fade stepping, two-stage duty
// pipeline and the on-window comparator. OFF shifts the window start within
// the period (zero when the window is anchored at phase 0).
module led_pwm_fader_channel
  import led_pwm_fader_pkg::*;
#(
  parameter int W   = 8,
  parameter int DW  = 10,
  parameter int PW  = 10,
  parameter int P   = 1000,
  parameter int S   = 3,
  parameter int OFF = 0
) (
  input  logic          clk,
  input  logic          arst,
  input  logic [PW-1:0] ph_next,
  input  logic          upd,
  input  logic          tick,
  input  logic          cap,
  input  logic          load,
  input  logic [W-1:0]  value,
  input  logic          fade_en,
  output logic          led,
  output logic          fade_done
);

  logic [W-1:0]  target, target_d;
  logic [W-1:0]  level, level_d;
  logic [DW-1:0] prod, duty, duty_d;
  logic [PW:0]   rel_raw, rel;
  t_fade_dir     dir;

  // Direction the level has to move to reach the target
  always_comb begin
    dir = FADE_HOLD;
    if (level < target)      dir = FADE_UP;
    else if (level > target) dir = FADE_DOWN;
  end

  // Next target/level: the update always sees the pre-load target
  always_comb begin
    target_d = load ? value : target;
    level_d  = level;
    if (upd) begin
      if (!fade_en) begin
        level_d = target;
      end else if (tick) begin
        case (dir)
          FADE_UP:   level_d = level + 1'b1;
          FADE_DOWN: level_d = level - 1'b1;
          default:   level_d = level;
        endcase
      end
    end
  end

  // Duty is only swapped at the period boundary; window position relative to OFF
  always_comb begin
    duty_d  = cap ? prod : duty;
    rel_raw = {1'b0, ph_next} + (PW+1)'(P - OFF);
    rel     = (rel_raw >= (PW+1)'(P)) ? rel_raw - (PW+1)'(P) : rel_raw;
  end

  // Channel state, duty pipeline and registered outputs
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      target    <= '0;
      level     <= '0;
      prod      <= '0;
      duty      <= '0;
      led       <= 1'b0;
      fade_done <= 1'b1;
    end else begin
      target    <= target_d;
      level     <= level_d;
      prod      <= DW'(level) * DW'(S);
      duty      <= duty_d;
      led       <= (rel < (PW+1)'(duty_d));
      fade_done <= (level_d == target_d);
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// N-channel LED PWM driver with optional linear fading. Holds the shared
// phase counter, fade tick counter and period strobe; per-channel logic
// lives in led_pwm_fader_channel.
// Optional build macro LED_PWM_FADER_PHASE_STAGGER_EN spreads the channel
// on-windows across the period (channel k starts at k*P/N).
module led_pwm_fader
  import led_pwm_fader_pkg::*;
#(
  parameter int parm_channel_count          = 16,
  parameter int parm_value_width            = 8,
  parameter int parm_FCLK                   = 40_000_000,
  parameter int parm_pwm_period_milliseconds = 10,
  parameter int parm_max_duty_percent       = 80,
  parameter int parm_fade_step_periods      = 1
) (
  input  logic                                        i_clk,
  input  logic                                        i_arst,
  input  logic [parm_channel_count*parm_value_width-1:0] i_value,
  input  logic                                        i_load,
  input  logic [parm_channel_count-1:0]               i_fade_en,
  output logic [parm_channel_count-1:0]               eo_leds,
  output logic                                        o_period_strobe,
  output logic [parm_channel_count-1:0]               o_fade_done
);

  localparam int N  = parm_channel_count;
  localparam int W  = parm_value_width;
  localparam int P  = calc_period(parm_FCLK, parm_pwm_period_milliseconds);
  localparam int D  = calc_duty_max(P, parm_max_duty_percent);
  localparam int S  = calc_step(D, W);
  localparam int FS = parm_fade_step_periods;
  localparam int PW = calc_width(P);
  localparam int DW = calc_width(D + 1);
  localparam int FW = calc_width(FS);

  if (P < 8 || S < 1 || FS < 1) begin : g_cfg_err
    $error("led_pwm_fader: period too short or duty step below one clock");
  end

  logic [PW-1:0] ph, ph_next;
  logic [FW-1:0] fcnt;
  logic          wrap, upd, tick;

  // Phase sequencing; level update sits at P-4 so the product is ready by P-1
  always_comb begin
    wrap    = (ph == PW'(P - 1));
    ph_next = wrap ? '0 : ph + 1'b1;
    upd     = (ph == PW'(P - 4));
    tick    = (fcnt == FW'(FS - 1));
  end

  // Phase counter, period strobe and fade tick counter
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      ph              <= '0;
      fcnt            <= '0;
      o_period_strobe <= 1'b0;
    end else begin
      ph              <= ph_next;
      o_period_strobe <= (ph_next == '0);
      if (wrap) fcnt <= tick ? '0 : fcnt + 1'b1;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_ch
`ifdef LED_PWM_FADER_PHASE_STAGGER_EN
    localparam int OFF_K = (k * P) / N;
`else
    localparam int OFF_K = 0;
`endif
    led_pwm_fader_channel #(
      .W(W), .DW(DW), .PW(PW), .P(P), .S(S), .OFF(OFF_K)
    ) u_ch (
      .clk      (i_clk),
      .arst     (i_arst),
      .ph_next  (ph_next),
      .upd      (upd),
      .tick     (tick),
      .cap      (wrap),
      .load     (i_load),
      .value    (i_value[k*W +: W]),
      .fade_en  (i_fade_en[k]),
      .led      (eo_leds[k]),
      .fade_done(o_fade_done[k])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader: FCLK 1 MHz, 1 ms, 80 %, W=8, N=4
// (P=1000, D=800, S=3). Phase is tracked bench-side from reset release.
module tb_led_pwm_fader;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 1000;
`ifdef LED_PWM_FADER_PHASE_STAGGER_EN
  localparam int STAG = 1;
`else
  localparam int STAG = 0;
`endif

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic           load = 1'b0;
  logic [N*W-1:0] value = '0;
  logic [N-1:0]   fade_en = '0;
  logic [N-1:0]   leds, done;
  logic           strobe;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .parm_channel_count(N), .parm_value_width(W), .parm_FCLK(1_000_000),
    .parm_pwm_period_milliseconds(1), .parm_max_duty_percent(80),
    .parm_fade_step_periods(1)
  ) dut (
    .i_clk(clk), .i_arst(arst), .i_value(value), .i_load(load),
    .i_fade_en(fade_en), .eo_leds(leds), .o_period_strobe(strobe),
    .o_fade_done(done)
  );

  int n_assert = 0;
  int n_fail = 0;
  int ph_m = 0;
  int hi[N], first[N], last[N], rise[N];
  int strobe_cnt, strobe_err;
  logic [N-1:0] prev_leds, mid_done;

  function automatic int off(input int k);
    return STAG ? (k * P) / N : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_acc();
    for (int k = 0; k < N; k++) begin
      hi[k] = 0; first[k] = -1; last[k] = -1; rise[k] = -1;
    end
    strobe_cnt = 0; strobe_err = 0; mid_done = '0; prev_leds = leds;
  endtask

  // Advance one clock, then sample the newly entered cycle
  task automatic tick();
    @(posedge clk); #1;
    ph_m = (ph_m + 1) % P;
    if (strobe) strobe_cnt++;
    if (strobe !== (ph_m == 0)) strobe_err++;
    if (ph_m == 500) mid_done = done;
    for (int k = 0; k < N; k++) begin
      if (leds[k]) begin
        hi[k]++;
        if (first[k] < 0) first[k] = ph_m;
        last[k] = ph_m;
        if (!prev_leds[k] && rise[k] < 0) rise[k] = ph_m;
      end
    end
    prev_leds = leds;
  endtask

  task automatic goto_ph(input int t);
    repeat ((t - ph_m + P) % P) tick();
  endtask

  // Accumulate samples for phases 0..P-1 of one full period
  task automatic period();
    goto_ph(P - 1);
    clear_acc();
    repeat (P) tick();
  endtask

  int exp_hi1[5] = '{3, 6, 9, 12, 12};
  int exp_md1[5] = '{0, 0, 0, 1, 1};

  initial begin
    clear_acc();
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_leds", 32'(leds), 0);
    check("rst_hold_done", 32'(done), 4'hF);
    arst = 1'b0;
    ph_m = 0;

    // 1: idle after reset
    check("s1_leds", 32'(leds), 0);
    check("s1_strobe", 32'(strobe), 0);
    check("s1_done", 32'(done), 4'hF);
    period();
    check("s1_hi_sum", hi[0] + hi[1] + hi[2] + hi[3], 0);
    check("s1_strobe_cnt", strobe_cnt, 1);
    check("s1_strobe_err", strobe_err, 0);
    period();
    check("s1_strobe_cnt2", strobe_cnt, 1);
    check("s1_strobe_err2", strobe_err, 0);

    // 2: jump ch0 to full scale, loaded at ph 100
    goto_ph(100);
    value = {8'd0, 8'd0, 8'd0, 8'd255};
    fade_en = 4'b0000;
    load = 1'b1; tick(); load = 1'b0;
    clear_acc();
    goto_ph(P - 1);
    check("s2_no_flash", hi[0] + hi[1] + hi[2] + hi[3], 0);
    check("s2_done_mid", 32'(mid_done), 4'b1110);
    check("s2_done_upd", 32'(done), 4'hF);
    period();
    check("s2_hi0", hi[0], 765);
    check("s2_first0", first[0], 0);
    check("s2_last0", last[0], 764);
    check("s2_rise0", rise[0], 0);
    check("s2_hi_other", hi[1] + hi[2] + hi[3], 0);
    check("s2_strobe_err", strobe_err, 0);

    // 3: fade ch1 up to 4, one step per period
    goto_ph(100);
    value = {8'd0, 8'd0, 8'd4, 8'd255};
    fade_en = 4'b0010;
    load = 1'b1; tick(); load = 1'b0;
    check("s3_done_load", 32'(done), 4'b1101);
    for (int i = 0; i < 5; i++) begin
      period();
      check($sformatf("s3_hi1_p%0d", i), hi[1], exp_hi1[i]);
      check($sformatf("s3_done1_p%0d", i), 32'(mid_done[1]), exp_md1[i]);
      check($sformatf("s3_rise1_p%0d", i), rise[1], off(1));
      check($sformatf("s3_hi0_p%0d", i), hi[0], 765);
    end

    // 4: load at P-5 (next period) and at the update cycle P-4 (one later)
    goto_ph(P - 5);
    value = {8'd0, 8'd10, 8'd4, 8'd255};
    fade_en = 4'b0000;
    load = 1'b1; tick();
    value = {8'd0, 8'd10, 8'd20, 8'd255};
    tick(); load = 1'b0;
    period();
    check("s4_hi1_old", hi[1], 12);
    check("s4_hi2_p5", hi[2], 30);
    period();
    check("s4_hi1_new", hi[1], 60);
    check("s4_hi2_hold", hi[2], 30);
    check("s4_hi0", hi[0], 765);

    // 5: reset pulse mid-fade at ph 500
    goto_ph(100);
    value = {8'd200, 8'd10, 8'd20, 8'd255};
    fade_en = 4'b1000;
    load = 1'b1; tick(); load = 1'b0;
    period();
    check("s5_hi3_fade", hi[3], 3);
    goto_ph(500);
    check("s5_led0_pre", 32'(leds[0]), 1);
    arst = 1'b1;
    #1;
    check("s5_leds_async", 32'(leds), 0);
    check("s5_done_async", 32'(done), 4'hF);
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    ph_m = 0;
    check("s5_leds_rel", 32'(leds), 0);
    check("s5_strobe_rel", 32'(strobe), 0);
    check("s5_done_rel", 32'(done), 4'hF);
    clear_acc();
    goto_ph(P - 1);
    check("s5_hi_first", hi[0] + hi[1] + hi[2] + hi[3], 0);
    check("s5_strobe_none", strobe_cnt, 0);
    period();
    check("s5_hi_sum", hi[0] + hi[1] + hi[2] + hi[3], 0);
    check("s5_strobe_cnt", strobe_cnt, 1);
    check("s5_strobe_err", strobe_err, 0);
    check("s5_done", 32'(done), 4'hF);

    // 6: all channels full scale; window start per channel offset
    goto_ph(100);
    value = {8'd255, 8'd255, 8'd255, 8'd255};
    fade_en = 4'b0000;
    load = 1'b1; tick(); load = 1'b0;
    period();
    period();
    for (int k = 0; k < N; k++) begin
      check($sformatf("s6_hi%0d", k), hi[k], 765);
      check($sformatf("s6_rise%0d", k), rise[k], off(k));
    end
    check("s6_first3", first[3], 0);
    check("s6_strobe_err", strobe_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
